// File: rtl/full_subtractor_pkg.sv
// ----------------------------------------------------------------------------
// full_subtractor_pkg
// Purpose : shared constants for the ripple-borrow subtractor slice.
// Contents: D_Q_RST_BIT - per-bit reset value of the registered difference.
// ----------------------------------------------------------------------------
package full_subtractor_pkg;

    // Registered difference clears to all zeros; replicated to WIDTH at use.
    localparam logic D_Q_RST_BIT = 1'b0;

endpackage : full_subtractor_pkg

// File: rtl/full_subtractor_bit.sv
// ----------------------------------------------------------------------------
// full_subtractor_bit
// Purpose : single 1-bit full-subtractor cell, d = a - b - bin.
// Ports   : a   - minuend bit
//           b   - subtrahend bit
//           bin - borrow in
//           d   - difference bit
//           bo  - borrow out
// ----------------------------------------------------------------------------
module full_subtractor_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bin;
    // Borrow whenever a is 0 and something is taken away, or both b and bin
    // need to be taken regardless of a.
    assign bo = (~a & b) | (~a & bin) | (b & bin);

endmodule : full_subtractor_bit

// File: rtl/full_subtractor.sv
// ----------------------------------------------------------------------------
// full_subtractor
// Purpose : WIDTH-bit ripple-borrow subtractor D = A - B - Bin with borrow-out,
//           plus a one-cycle registered copy qualified by a valid flag.
// Ports   : clk     - rising-edge clock for the output register stage
//           rst     - asynchronous active-high reset (registered outputs only)
//           a, b    - minuend / subtrahend, WIDTH bits
//           bin     - borrow into the LSB cell
//           in_vld  - qualifies a/b/bin for capture
//           d, bo   - combinational difference / borrow-out
//           d_q     - registered difference
//           bo_q    - registered borrow-out
//           out_vld - high the cycle after in_vld is sampled high
// ----------------------------------------------------------------------------
module full_subtractor
    import full_subtractor_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    input  logic             in_vld,
    output logic [WIDTH-1:0] d,
    output logic             bo,
    output logic [WIDTH-1:0] d_q,
    output logic             bo_q,
    output logic             out_vld
);

    localparam logic [WIDTH-1:0] D_Q_RST = {WIDTH{D_Q_RST_BIT}};

    // w_br[i] is the borrow into cell i; w_br[WIDTH] is the final borrow-out.
    logic [WIDTH:0]   w_br;
    logic [WIDTH-1:0] w_d;

    logic [WIDTH-1:0] r_d_q;
    logic             r_bo_q;
    logic             r_out_vld;

    assign w_br[0] = bin;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        full_subtractor_bit u_cell (
            .a   (a[gi]),
            .b   (b[gi]),
            .bin (w_br[gi]),
            .d   (w_d[gi]),
            .bo  (w_br[gi+1])
        );
    end

    assign d  = w_d;
    assign bo = w_br[WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d_q     <= D_Q_RST;
            r_bo_q    <= 1'b0;
            r_out_vld <= 1'b0;
        end else begin
            r_out_vld <= in_vld;
            if (in_vld) begin
                r_d_q  <= w_d;
                r_bo_q <= w_br[WIDTH];
            end
        end
    end

    assign d_q     = r_d_q;
    assign bo_q    = r_bo_q;
    assign out_vld = r_out_vld;

endmodule : full_subtractor

// File: tb/tb_full_subtractor.sv
// ----------------------------------------------------------------------------
// tb_full_subtractor
// Purpose : directed and random checks of full_subtractor at WIDTH=1 and
//           WIDTH=8, covering the combinational path, register stage and
//           asynchronous reset.
// ----------------------------------------------------------------------------
module tb_full_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_vld;

    logic [0:0] a1, b1, d1, d1_q;
    logic       bin1, bo1, bo1_q, vld1;

    logic [7:0] a8, b8, d8, d8_q;
    logic       bin8, bo8, bo8_q, vld8;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Truth table indexed by {a,b,bin}
    logic [7:0] tt_d  = 8'b1001_0110;
    logic [7:0] tt_bo = 8'b1000_1110;

    logic [8:0] mdl;
    logic [1:0] mdl1;
    logic [7:0] exp_dq;
    logic       exp_boq;
    logic       exp_vld;

    always #5 clk = ~clk;

    full_subtractor #(.WIDTH(1)) u_dut1 (
        .clk     (clk),
        .rst     (rst),
        .a       (a1),
        .b       (b1),
        .bin     (bin1),
        .in_vld  (in_vld),
        .d       (d1),
        .bo      (bo1),
        .d_q     (d1_q),
        .bo_q    (bo1_q),
        .out_vld (vld1)
    );

    full_subtractor #(.WIDTH(8)) u_dut8 (
        .clk     (clk),
        .rst     (rst),
        .a       (a8),
        .b       (b8),
        .bin     (bin8),
        .in_vld  (in_vld),
        .d       (d8),
        .bo      (bo8),
        .d_q     (d8_q),
        .bo_q    (bo8_q),
        .out_vld (vld8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst    = 1'b1;
        in_vld = 1'b0;
        a1 = '0; b1 = '0; bin1 = 1'b0;
        a8 = '0; b8 = '0; bin8 = 1'b0;
        #1;
        chk("rst_d8_q",   32'(d8_q),  32'h00);
        chk("rst_bo8_q",  32'(bo8_q), 32'h0);
        chk("rst_vld8",   32'(vld8),  32'h0);
        chk("rst_d1_q",   32'(d1_q),  32'h0);
        chk("rst_vld1",   32'(vld1),  32'h0);

        // WIDTH=1 exhaustive sweep, held in reset to show d/bo ignore it
        for (int unsigned i = 0; i < 8; i++) begin
            {a1[0], b1[0], bin1} = 3'(i);
            #10;
            chk($sformatf("tt_d_%0d", i),  32'(d1),  32'(tt_d[i]));
            chk($sformatf("tt_bo_%0d", i), 32'(bo1), 32'(tt_bo[i]));
        end

        @(negedge clk);
        rst = 1'b0;

        // WIDTH=8 boundary and directed vectors
        a8 = 8'h00; b8 = 8'hFF; bin8 = 1'b1; #1;
        chk("full_borrow_d",  32'(d8),  32'h00);
        chk("full_borrow_bo", 32'(bo8), 32'h1);
        a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b0; #1;
        chk("ones_d",  32'(d8),  32'hFF);
        chk("ones_bo", 32'(bo8), 32'h0);
        a8 = 8'h5A; b8 = 8'h3C; bin8 = 1'b0; #1;
        chk("5a_3c_d",  32'(d8),  32'h1E);
        chk("5a_3c_bo", 32'(bo8), 32'h0);

        // Registered path: capture, then hold with in_vld low
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h00; bin8 = 1'b0; in_vld = 1'b1;
        @(posedge clk); #1;
        chk("cap1_d_q",  32'(d8_q),  32'h01);
        chk("cap1_bo_q", 32'(bo8_q), 32'h0);
        chk("cap1_vld",  32'(vld8),  32'h1);
        @(negedge clk);
        a8 = 8'h00; b8 = 8'h01; bin8 = 1'b0;
        @(posedge clk); #1;
        chk("cap2_d_q",  32'(d8_q),  32'hFF);
        chk("cap2_bo_q", 32'(bo8_q), 32'h1);
        @(negedge clk);
        in_vld = 1'b0; a8 = 8'h10; b8 = 8'h01;
        @(posedge clk); #1;
        chk("hold_d_q",  32'(d8_q),  32'hFF);
        chk("hold_bo_q", 32'(bo8_q), 32'h1);
        chk("hold_vld",  32'(vld8),  32'h0);

        // Async reset between edges while out_vld is high
        @(negedge clk);
        in_vld = 1'b1; a8 = 8'h00; b8 = 8'h01; bin8 = 1'b0;
        a1 = 1'b0; b1 = 1'b1; bin1 = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_vld",  32'(vld8),  32'h1);
        chk("pre_rst_vld1", 32'(vld1),  32'h1);
        chk("pre_rst_d1_q", 32'(d1_q),  32'h1);
        #2;
        rst = 1'b1;
        a8  = 8'h80; b8 = 8'h01;
        #1;
        chk("arst_d_q",  32'(d8_q),  32'h00);
        chk("arst_bo_q", 32'(bo8_q), 32'h0);
        chk("arst_vld",  32'(vld8),  32'h0);
        chk("arst_d1_q", 32'(d1_q),  32'h0);
        chk("arst_d",    32'(d8),    32'h7F);
        chk("arst_bo",   32'(bo8),   32'h0);
        // in_vld stays high across an edge while reset is held: dropped
        @(posedge clk); #1;
        chk("rst_hold_d_q", 32'(d8_q), 32'h00);
        chk("rst_hold_vld", 32'(vld8), 32'h0);

        // Reset release: first capture at first edge with rst low
        @(negedge clk);
        rst = 1'b0;
        a8 = 8'h00; b8 = 8'h01; bin8 = 1'b0;
        a1 = 1'b0;  b1 = 1'b1;  bin1 = 1'b0;
        in_vld = 1'b1;
        @(posedge clk); #1;
        chk("rel_d1_q",  32'(d1_q),  32'h1);
        chk("rel_bo1_q", 32'(bo1_q), 32'h1);
        chk("rel_vld1",  32'(vld1),  32'h1);
        chk("rel_d8_q",  32'(d8_q),  32'hFF);
        chk("rel_bo8_q", 32'(bo8_q), 32'h1);
        exp_dq  = 8'hFF;
        exp_boq = 1'b1;

        // Random regression against an arithmetic reference
        for (int unsigned n = 0; n < 1000; n++) begin
            @(negedge clk);
            a8     = 8'($urandom);
            b8     = 8'($urandom);
            bin8   = 1'($urandom);
            a1     = 1'($urandom);
            b1     = 1'($urandom);
            bin1   = 1'($urandom);
            in_vld = 1'($urandom);
            #1;
            mdl  = {1'b0, a8} - {1'b0, b8} - 9'(bin8);
            mdl1 = {1'b0, a1} - {1'b0, b1} - 2'(bin1);
            chk("rnd_d8",  32'(d8),  32'(mdl[7:0]));
            chk("rnd_bo8", 32'(bo8), 32'(mdl[8]));
            chk("rnd_d1",  32'(d1),  32'(mdl1[0]));
            chk("rnd_bo1", 32'(bo1), 32'(mdl1[1]));
            if (in_vld) begin
                exp_dq  = mdl[7:0];
                exp_boq = mdl[8];
            end
            exp_vld = in_vld;
            @(posedge clk); #1;
            chk("rnd_d8_q",  32'(d8_q),  32'(exp_dq));
            chk("rnd_bo8_q", 32'(bo8_q), 32'(exp_boq));
            chk("rnd_vld8",  32'(vld8),  32'(exp_vld));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_full_subtractor
